// File: rtl/reg_file_8x16.sv
// Eight-entry register file: one synchronous write port, two combinational read ports (R, S)
// with optional write-first forwarding and an optional hard-wired zero register.
module reg_file_8x16 #(
   parameter int WIDTH      = 16,
   parameter int DEPTH_LOG2 = 3,
   parameter int R0_ZERO    = 0,
   parameter int BYPASS     = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  W,
   input  logic [DEPTH_LOG2-1:0] W_Adr,
   input  logic [DEPTH_LOG2-1:0] R_Adr,
   input  logic [DEPTH_LOG2-1:0] S_Adr,
   input  logic [WIDTH-1:0]      WR,
   output logic [WIDTH-1:0]      R,
   output logic [WIDTH-1:0]      S,
   output logic                  W_busy
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [WIDTH-1:0] regs [DEPTH];
   logic [DEPTH-1:0] wr_dec;
   logic             wr_commit;

   // One-hot write decode; a write to a hard-wired zero register never decodes.
   always_comb begin
      wr_dec = '0;
      if (W && !((R0_ZERO != 0) && (W_Adr == '0)))
         wr_dec[W_Adr] = 1'b1;
   end

   assign wr_commit = |wr_dec;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++)
            regs[i] <= '0;
         W_busy <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++)
            if (wr_dec[i])
               regs[i] <= WR;
         W_busy <= wr_commit;
      end
   end

   function automatic logic [WIDTH-1:0] read_port(
      input logic [DEPTH_LOG2-1:0] adr,
      input logic                  fwd,
      input logic [WIDTH-1:0]      wdata,
      input logic [WIDTH-1:0]      stored
   );
      if ((R0_ZERO != 0) && (adr == '0))
         return '0;
      if ((BYPASS != 0) && fwd)
         return wdata;
      return stored;
   endfunction

   // Forwarding uses the decoded write, so dropped and reset-cycle writes never forward.
   always_comb begin
      R = read_port(R_Adr, wr_dec[R_Adr] && !reset, WR, regs[R_Adr]);
      S = read_port(S_Adr, wr_dec[S_Adr] && !reset, WR, regs[S_Adr]);
   end

endmodule

// File: tb/tb_reg_file_8x16.sv
// Bench for reg_file_8x16: three configurations share one stimulus stream
// (a: R0_ZERO=0/BYPASS=1, b: R0_ZERO=0/BYPASS=0, z: R0_ZERO=1/BYPASS=1).
module tb_reg_file_8x16;

   logic        clk = 1'b0;
   logic        reset;
   logic        W;
   logic [2:0]  W_Adr, R_Adr, S_Adr;
   logic [15:0] WR;
   logic [15:0] r_a, s_a, r_b, s_b, r_z, s_z;
   logic        busy_a, busy_b, busy_z;

   int n_chk  = 0;
   int n_pass = 0;

   logic [15:0] m  [8];
   logic [15:0] mz [8];
   logic        mbusy, mbusy_z;
   logic [15:0] e_ar, e_as, e_br, e_bs, e_zr, e_zs;
   logic        fwd_r, fwd_s;

   always #5 clk = ~clk;

   reg_file_8x16 #(.WIDTH(16), .DEPTH_LOG2(3), .R0_ZERO(0), .BYPASS(1)) dut_a (
      .clk(clk), .reset(reset), .W(W), .W_Adr(W_Adr), .R_Adr(R_Adr), .S_Adr(S_Adr),
      .WR(WR), .R(r_a), .S(s_a), .W_busy(busy_a));

   reg_file_8x16 #(.WIDTH(16), .DEPTH_LOG2(3), .R0_ZERO(0), .BYPASS(0)) dut_b (
      .clk(clk), .reset(reset), .W(W), .W_Adr(W_Adr), .R_Adr(R_Adr), .S_Adr(S_Adr),
      .WR(WR), .R(r_b), .S(s_b), .W_busy(busy_b));

   reg_file_8x16 #(.WIDTH(16), .DEPTH_LOG2(3), .R0_ZERO(1), .BYPASS(1)) dut_z (
      .clk(clk), .reset(reset), .W(W), .W_Adr(W_Adr), .R_Adr(R_Adr), .S_Adr(S_Adr),
      .WR(WR), .R(r_z), .S(s_z), .W_busy(busy_z));

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled before the next edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] adr, input logic [15:0] d);
      W = 1'b1; W_Adr = adr; WR = d;
      tick();
      W = 1'b0;
   endtask

   initial begin
      reset = 1'b1; W = 1'b0; W_Adr = '0; R_Adr = '0; S_Adr = '0; WR = '0;
      tick();
      reset = 1'b0;
      #1;
      chk("rst_r_a", r_a, 16'h0000);
      chk("rst_s_b", s_b, 16'h0000);
      chk("rst_busy_a", {15'b0, busy_a}, 16'h0000);
      chk("rst_busy_z", {15'b0, busy_z}, 16'h0000);

      // Reset clear, with a write attempted during the reset cycle
      for (int k = 0; k < 8; k++) wr(k[2:0], 16'hFFFF);
      reset = 1'b1; W = 1'b1; W_Adr = 3'd3; WR = 16'h1234; R_Adr = 3'd3; S_Adr = 3'd3;
      #1;
      chk("rst_cycle_no_fwd_a", r_a, 16'hFFFF);
      tick();
      reset = 1'b0; W = 1'b0;
      #1;
      chk("rstclr_busy_a", {15'b0, busy_a}, 16'h0000);
      chk("rstclr_busy_b", {15'b0, busy_b}, 16'h0000);
      for (int k = 0; k < 8; k++) begin
         R_Adr = k[2:0]; S_Adr = k[2:0];
         #1;
         chk($sformatf("rstclr_r_a%0d", k), r_a, 16'h0000);
         chk($sformatf("rstclr_s_a%0d", k), s_a, 16'h0000);
      end

      // Write / readback sweep
      for (int k = 0; k < 8; k++) begin
         wr(k[2:0], 16'h1111 * k[15:0]);
         chk($sformatf("wb_busy_a%0d", k), {15'b0, busy_a}, 16'h0001);
         chk($sformatf("wb_busy_z%0d", k), {15'b0, busy_z}, (k == 0) ? 16'h0000 : 16'h0001);
      end
      for (int k = 0; k < 8; k++) begin
         R_Adr = k[2:0]; S_Adr = 3'(7 - k);
         #1;
         chk($sformatf("wb_r_a%0d", k), r_a, 16'h1111 * k[15:0]);
         chk($sformatf("wb_s_a%0d", k), s_a, 16'h1111 * 16'(7 - k));
         chk($sformatf("wb_r_b%0d", k), r_b, 16'h1111 * k[15:0]);
         chk($sformatf("wb_r_z%0d", k), r_z, (k == 0) ? 16'h0000 : 16'h1111 * k[15:0]);
         chk($sformatf("wb_s_z%0d", k), s_z, (k == 7) ? 16'h0000 : 16'h1111 * 16'(7 - k));
      end
      tick();
      chk("wb_busy_drop_a", {15'b0, busy_a}, 16'h0000);

      // Bypass versus no bypass
      wr(3'd5, 16'h00AA);
      W = 1'b1; W_Adr = 3'd5; WR = 16'h5555; R_Adr = 3'd5; S_Adr = 3'd5;
      #1;
      chk("byp_r_a", r_a, 16'h5555);
      chk("byp_s_a", s_a, 16'h5555);
      chk("nobyp_r_b", r_b, 16'h00AA);
      chk("nobyp_s_b", s_b, 16'h00AA);
      tick();
      W = 1'b0;
      #1;
      chk("nobyp_after_r_b", r_b, 16'h5555);
      chk("nobyp_after_s_b", s_b, 16'h5555);

      // Hard-wired zero register
      W = 1'b1; W_Adr = 3'd0; WR = 16'hBEEF; R_Adr = 3'd0; S_Adr = 3'd0;
      #1;
      chk("r0_byp_r_z", r_z, 16'h0000);
      chk("r0_byp_s_z", s_z, 16'h0000);
      chk("r0_byp_r_a", r_a, 16'hBEEF);
      tick();
      W = 1'b0;
      #1;
      chk("r0_r_z", r_z, 16'h0000);
      chk("r0_s_z", s_z, 16'h0000);
      chk("r0_busy_z", {15'b0, busy_z}, 16'h0000);
      chk("r0_busy_a", {15'b0, busy_a}, 16'h0001);

      // Write enable low
      wr(3'd2, 16'h0F0F);
      W = 1'b0; W_Adr = 3'd2; WR = 16'hDEAD; R_Adr = 3'd2; S_Adr = 3'd2;
      tick();
      chk("wdis_r_a", r_a, 16'h0F0F);
      chk("wdis_s_b", s_b, 16'h0F0F);
      chk("wdis_busy_a", {15'b0, busy_a}, 16'h0000);

      // Randomized run against a reference model, with periodic reset
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin m[i] = '0; mz[i] = '0; end
      mbusy = 1'b0; mbusy_z = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         reset = (c % 250 == 249) || ($urandom_range(0, 63) == 0);
         W     = $urandom_range(0, 1) == 1;
         W_Adr = 3'($urandom_range(0, 7));
         R_Adr = 3'($urandom_range(0, 7));
         S_Adr = ($urandom_range(0, 3) == 0) ? W_Adr : 3'($urandom_range(0, 7));
         WR    = 16'($urandom);
         #1;
         fwd_r = W && !reset && (W_Adr == R_Adr);
         fwd_s = W && !reset && (W_Adr == S_Adr);
         e_ar = fwd_r ? WR : m[R_Adr];
         e_as = fwd_s ? WR : m[S_Adr];
         e_br = m[R_Adr];
         e_bs = m[S_Adr];
         e_zr = (R_Adr == 3'd0) ? 16'h0000 : (fwd_r ? WR : mz[R_Adr]);
         e_zs = (S_Adr == 3'd0) ? 16'h0000 : (fwd_s ? WR : mz[S_Adr]);
         chk("rnd_r_a", r_a, e_ar);
         chk("rnd_s_a", s_a, e_as);
         chk("rnd_r_b", r_b, e_br);
         chk("rnd_s_b", s_b, e_bs);
         chk("rnd_r_z", r_z, e_zr);
         chk("rnd_s_z", s_z, e_zs);
         if (reset) begin
            for (int i = 0; i < 8; i++) begin m[i] = '0; mz[i] = '0; end
            mbusy = 1'b0; mbusy_z = 1'b0;
         end else begin
            mbusy   = W;
            mbusy_z = W && (W_Adr != 3'd0);
            if (W) m[W_Adr] = WR;
            if (mbusy_z) mz[W_Adr] = WR;
         end
         tick();
         chk("rnd_busy_a", {15'b0, busy_a}, {15'b0, mbusy});
         chk("rnd_busy_b", {15'b0, busy_b}, {15'b0, mbusy});
         chk("rnd_busy_z", {15'b0, busy_z}, {15'b0, mbusy_z});
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
